// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Contents: fetch FSM state type, instruction width/size, word-alignment mask.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [1:0]  ALIGN_MASK  = 2'b11;

endpackage

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: drives a registered byte PC into a combinational
// instruction memory and captures the returned word, with its PC, into a
// valid/ready output stage feeding decode.
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   enable                       start/continue fetching
//   pc_out / inst_in             address to memory / word returned same cycle
//   redirect_valid/_target       branch/jump: load new PC and flush output stage
//   id_valid/id_ready            output handshake to decode
//   id_instr/id_pc               fetched instruction and its address
//   halted                       PC ran past end of memory
//   misaligned                   sticky fault on an unaligned redirect target
//   fetch_count                  saturating count of fetched instructions
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 32,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    output logic [31:0]         pc_out,
    input  logic [INSTR_W-1:0]  inst_in,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_target,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [INSTR_W-1:0]  id_instr,
    output logic [31:0]         id_pc,
    output logic                halted,
    output logic                misaligned,
    output logic [CNT_W-1:0]    fetch_count
);

    // Highest address holding a full instruction; compared directly so no +3 overflow.
    localparam logic [31:0]      LAST_PC    = 32'(MEM_BYTES - INSTR_BYTES);
    localparam logic [31:0]      RESET_ADDR = 32'(RESET_PC);
    localparam logic [31:0]      PC_STEP    = 32'(INSTR_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t state;
    state_t state_nxt;

    logic in_range_c;
    logic target_aligned_c;
    logic fetch_c;
    logic load_pc_c;
    logic fault_c;
    logic halt_c;

    assign in_range_c       = (pc_out <= LAST_PC);
    assign target_aligned_c = ((redirect_target[1:0] & ALIGN_MASK) == 2'b00);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle datapath controls; redirect outranks everything.
    always_comb begin
        state_nxt = state;
        fetch_c   = 1'b0;
        load_pc_c = 1'b0;
        fault_c   = 1'b0;
        halt_c    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    load_pc_c = target_aligned_c;
                    fault_c   = !target_aligned_c;
                    state_nxt = target_aligned_c ? RUN : FAULT;
                end else if (!in_range_c) begin
                    halt_c    = 1'b1;
                    state_nxt = HALT;
                end else begin
                    fetch_c = enable && (!id_valid || id_ready);
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    load_pc_c = target_aligned_c;
                    fault_c   = !target_aligned_c;
                    state_nxt = target_aligned_c ? RUN : FAULT;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // PC, output stage and status registers; everything freezes once faulted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_out      <= RESET_ADDR;
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            halted      <= 1'b0;
            misaligned  <= 1'b0;
            fetch_count <= '0;
        end else if (state != FAULT) begin
            if (load_pc_c) begin
                // Flush whatever is pending, even if decode is taking it this cycle.
                pc_out   <= redirect_target;
                id_valid <= 1'b0;
                halted   <= 1'b0;
            end else if (fault_c) begin
                misaligned <= 1'b1;
                id_valid   <= 1'b0;
            end else if (fetch_c) begin
                id_instr <= inst_in;
                id_pc    <= pc_out;
                id_valid <= 1'b1;
                pc_out   <= pc_out + PC_STEP;
                if (fetch_count != CNT_MAX) begin
                    fetch_count <= fetch_count + CNT_W'(1);
                end
            end else begin
                if (halt_c) begin
                    halted <= 1'b1;
                end
                // Drain an accepted instruction when nothing replaces it.
                if (id_valid && id_ready) begin
                    id_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch front end that drives the byte address into the combinational instruction memory and registers each returned 32-bit instruction, with its PC, into a valid/ready stage feeding decode. Sequential PC stepping by 4, redirect (branch/jump) with flush, end-of-memory halt, and a misaligned-target fault. Sits between the instruction memory (responder) and the decode stage (consumer).

## Interface
- MEM_BYTES, 32: instruction memory size in bytes, multiple of 4
- RESET_PC, 0: PC loaded on reset, word-aligned
- CNT_W, 16: fetch counter width

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  start/continue fetching
- pc_out  out  32  byte address to instruction memory (registered)
- inst_in  in  32  instruction word from memory, combinational from pc_out, same cycle
- redirect_valid  in  1  load new PC this cycle
- redirect_target  in  32  new PC
- id_valid  out  1  id_instr/id_pc hold a fetched instruction
- id_ready  in  1  decode accepts this cycle
- id_instr  out  32  fetched instruction
- id_pc  out  32  address of id_instr
- halted  out  1  PC ran past end of memory
- misaligned  out  1  sticky fault: redirect target not word-aligned
- fetch_count  out  CNT_W  instructions fetched, saturating

## Operation
- States: IDLE, RUN, HALT, FAULT. Reset → IDLE.
- Reset values: pc_out=RESET_PC, id_valid=0, id_instr=0, id_pc=0, halted=0, misaligned=0, fetch_count=0.
- IDLE: enable=1 → RUN next cycle; no fetch in IDLE; redirect ignored.
- in_range = (pc_out <= MEM_BYTES-4), unsigned 32-bit compare (no +3 overflow).
- Fetch condition (RUN): enable && in_range && !redirect_valid && (!id_valid || id_ready).
- On fetch: id_instr<=inst_in, id_pc<=pc_out, id_valid<=1, pc_out<=pc_out+4 (mod 2^32), fetch_count+1 saturating at all-ones.
- id_valid && id_ready without fetch → id_valid<=0.
- Stall: id_valid && !id_ready → id_instr, id_pc, pc_out held.
- enable=0 in RUN: no fetch, pending output drains normally, state stays RUN.
- RUN && !in_range && !redirect_valid → HALT; halted=1. Pending output still drains in HALT.
- Redirect (RUN or HALT), highest priority:
  - redirect_target[1:0]==0: pc_out<=target, id_valid<=0 (flush, even if id_ready), no fetch that cycle, halted<=0, state RUN.
  - else: state FAULT, misaligned<=1, id_valid<=0, pc_out held.
- Redirect to an aligned out-of-range target: RUN for one cycle, then HALT.
- FAULT: no fetch, all inputs ignored, outputs frozen until reset_n.
- reset_n low mid-operation: all state returns to reset values immediately, asynchronously.

## Timing
- pc_out registered; inst_in sampled on the same cycle's rising edge.
- Latency: pc_out presented in cycle N → id_instr/id_valid valid in N+1.
- enable high in cycle 0 after reset release → RUN in cycle 1 → first id_valid in cycle 2 (pc 0).
- Throughput: one instruction/cycle while id_ready=1.
- Redirect in cycle N: id_valid=0 in N+1, first instruction from target valid in N+2.
- halted/misaligned asserted the cycle after the triggering condition.

## Structure
- Package fetch_pkg: state enum (IDLE, RUN, HALT, FAULT), INSTR_W=32, INSTR_BYTES=4, alignment mask 2'b11.
- Single module; no sub-module. Output register and FSM inline; target 150–250 lines.

## Test plan
- Memory image words 0x00940333 @0, 0x413903b3 @4, 0x035a02b3 @8, 0x00f768b3 @28; enable=1, id_ready=1 → id_pc 0,4,…,28 on consecutive cycles, id_instr matching, then halted=1, fetch_count=8.
- id_ready=0 for 3 cycles while id_valid with id_pc=4 → id_instr=0x413903b3 and pc_out=8 held; resumes with id_pc=8 on release.
- redirect_valid with target 24 while id_pc=8 pending and id_ready=1 → pc 8 instruction dropped (id_valid=0 next cycle), then id_pc=24, 28, halted.
- In HALT, redirect to 4 → halted=0, id_pc=4 two cycles later, fetch resumes.
- redirect_target 0x0000000A → misaligned=1, id_valid=0, FAULT; further enable/redirect ignored; only reset_n recovers.
- reset_n pulled low mid-stream at id_pc=12 → all outputs to reset values immediately; refetch starts at 0 after enable.
